// File: rtl/jit_template_emitter.sv
// Multi-word ARM template sequencer: reads a run of words from a synchronous ROM,
// patches condition / imm fields, and streams them through a 2-entry output FIFO.
module jit_template_emitter #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 4,
    parameter int PATCH_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_base,
    input  logic [LEN_W-1:0]   req_len,
    input  logic               req_cond_en,
    input  logic [3:0]         req_cond,
    input  logic               req_patch_en,
    input  logic [LEN_W-1:0]   req_patch_idx,
    input  logic [PATCH_W-1:0] req_patch_val,
    output logic               rom_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0]  rom_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_last,
    output logic               err_len0,
    output logic               o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never depends on ready, and a raised out_valid holds its data until taken.

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_base;
    logic [LEN_W-1:0]    r_len;
    logic                r_cond_en;
    logic [3:0]          r_cond;
    logic                r_patch_en;
    logic [LEN_W-1:0]    r_patch_idx;
    logic [PATCH_W-1:0]  r_patch_val;
    logic [LEN_W-1:0]    r_issue_cnt;
    logic [LEN_W-1:0]    r_rd_k;
    logic                r_inflight;
    logic                r_err_len0;

    logic [DATA_W-1:0]   r_fifo_data [2];
    logic                r_fifo_last [2];
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_count;

    logic                w_accept;
    logic                w_pop;
    logic                w_issue;
    logic [2:0]          w_pending;
    logic [DATA_W-1:0]   w_word;
    logic                w_word_last;

    assign req_ready   = (r_state == ST_IDLE);
    assign w_accept    = req_valid && req_ready;
    assign out_valid   = (r_count != 2'd0);
    assign out_data    = r_fifo_data[r_rd_ptr];
    assign out_last    = r_fifo_last[r_rd_ptr];
    assign w_pop       = out_valid && out_ready;
    assign err_len0    = r_err_len0;
    assign o_dbg_state = r_state;

    // Buffered plus in-flight words may not exceed the two FIFO slots after this edge.
    assign w_pending = 3'(r_count) + 3'(r_inflight);
    assign w_issue   = (r_state == ST_RUN) && (r_issue_cnt != r_len) &&
                       ((w_pending - 3'(w_pop)) < 3'd2);

    assign rom_en   = w_issue;
    assign rom_addr = r_base + ADDR_W'(r_issue_cnt);

    always_comb begin
        w_word = rom_data;
        if (r_patch_en && (r_rd_k == r_patch_idx)) begin
            w_word[PATCH_W-1:0] = r_patch_val;
        end
        if (r_cond_en) begin
            w_word[DATA_W-1 -: 4] = r_cond;
        end
        w_word_last = (r_rd_k == (r_len - LEN_W'(1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_base      <= '0;
            r_len       <= '0;
            r_cond_en   <= 1'b0;
            r_cond      <= '0;
            r_patch_en  <= 1'b0;
            r_patch_idx <= '0;
            r_patch_val <= '0;
            r_issue_cnt <= '0;
            r_rd_k      <= '0;
            r_inflight  <= 1'b0;
            r_err_len0  <= 1'b0;
        end else begin
            r_err_len0 <= w_accept && (req_len == '0);
            r_inflight <= w_issue;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && (req_len != '0)) begin
                        r_state     <= ST_RUN;
                        r_base      <= req_base;
                        r_len       <= req_len;
                        r_cond_en   <= req_cond_en;
                        r_cond      <= req_cond;
                        r_patch_en  <= req_patch_en;
                        r_patch_idx <= req_patch_idx;
                        r_patch_val <= req_patch_val;
                        r_issue_cnt <= '0;
                        r_rd_k      <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_issue) begin
                        r_issue_cnt <= r_issue_cnt + LEN_W'(1);
                        r_rd_k      <= r_issue_cnt;
                    end
                    if (w_pop && out_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_last[0] <= 1'b0;
            r_fifo_last[1] <= 1'b0;
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_count        <= 2'd0;
        end else begin
            if (r_inflight) begin
                r_fifo_data[r_wr_ptr] <= w_word;
                r_fifo_last[r_wr_ptr] <= w_word_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({r_inflight, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
